// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - WB stage: MEM/WB register, load align/extend, 2-deep forwarding history.
// Optional retire counter is built only when WB_RETIRE_COUNT_EN is defined.
module writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int HIST_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [2:0]        in_load_type,
    input  logic [1:0]        in_byte_off,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] write_result,
    output logic [ADDR_W-1:0] write_addr,
    output logic              register_write,
    input  logic [ADDR_W-1:0] query_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retire_count
);

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    logic              capture;
    logic              wr_en;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] wdata;

    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_result_q, write_result_d;

    logic              hist_valid_q [HIST_DEPTH];
    logic [ADDR_W-1:0] hist_addr_q  [HIST_DEPTH];
    logic [DATA_W-1:0] hist_data_q  [HIST_DEPTH];

    assign in_ready = !stall;
    assign capture  = in_valid && !stall && !flush;
    assign wr_en    = in_reg_write && (in_dest != '0);

    always_comb begin
        byte_sel = in_mem_data[7:0];
        case (in_byte_off)
            2'd1:    byte_sel = in_mem_data[15:8];
            2'd2:    byte_sel = in_mem_data[23:16];
            2'd3:    byte_sel = in_mem_data[31:24];
            default: byte_sel = in_mem_data[7:0];
        endcase
        half_sel = in_byte_off[1] ? in_mem_data[31:16] : in_mem_data[15:0];

        case (in_load_type)
            LT_LB:   load_val = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LT_LBU:  load_val = {{(DATA_W-8){1'b0}}, byte_sel};
            LT_LH:   load_val = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LT_LHU:  load_val = {{(DATA_W-16){1'b0}}, half_sel};
            default: load_val = in_mem_data;
        endcase
        wdata = in_mem_to_reg ? load_val : in_alu_result;
    end

    // Address/data hold their last values when nothing is captured.
    always_comb begin
        reg_write_d    = capture && wr_en;
        write_addr_d   = capture ? in_dest : write_addr_q;
        write_result_d = capture ? wdata : write_result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q    <= 1'b0;
            write_addr_q   <= '0;
            write_result_q <= '0;
        end else begin
            reg_write_q    <= reg_write_d;
            write_addr_q   <= write_addr_d;
            write_result_q <= write_result_d;
        end
    end

    assign register_write = reg_write_q;
    assign write_addr     = write_addr_q;
    assign write_result   = write_result_q;

    // History loads at the capture edge, so entry0 is live while register_write is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_valid_q[i] <= 1'b0;
                hist_addr_q[i]  <= '0;
                hist_data_q[i]  <= '0;
            end
        end else if (capture && wr_en) begin
            for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                hist_valid_q[i] <= hist_valid_q[i-1];
                hist_addr_q[i]  <= hist_addr_q[i-1];
                hist_data_q[i]  <= hist_data_q[i-1];
            end
            hist_valid_q[0] <= 1'b1;
            hist_addr_q[0]  <= in_dest;
            hist_data_q[0]  <= wdata;
        end
    end

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
            if (query_addr != '0 && hist_valid_q[i] && hist_addr_q[i] == query_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = hist_data_q[i];
            end
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retire_q, retire_d;

    assign retire_d = capture ? retire_q + 32'd1 : retire_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - Scoreboard bench for writeback_stage: directed cases plus random traffic.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_reg_write, in_mem_to_reg;
    logic [4:0]  in_dest;
    logic [31:0] in_alu_result, in_mem_data;
    logic [2:0]  in_load_type;
    logic [1:0]  in_byte_off;
    logic        stall, flush;
    logic [31:0] write_result;
    logic [4:0]  write_addr;
    logic        register_write;
    logic [4:0]  query_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [31:0] retire_count;

    writeback_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_dest(in_dest), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_load_type(in_load_type), .in_byte_off(in_byte_off),
        .stall(stall), .flush(flush),
        .write_result(write_result), .write_addr(write_addr), .register_write(register_write),
        .query_addr(query_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        time         t;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [4:0]  hist_a[$];
    logic [31:0] hist_d[$];
    logic [31:0] model_cnt;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_wdata(input logic m2r, input logic [31:0] alu,
                                              input logic [31:0] mem, input logic [2:0] lt,
                                              input logic [1:0] off);
        logic [31:0] b, h;
        b = (mem >> (8 * off)) & 32'hFF;
        h = off[1] ? (mem >> 16) : (mem & 32'hFFFF);
        if (!m2r) return alu;
        case (lt)
            3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return h;
            default: return mem;
        endcase
    endfunction

    function automatic logic [32:0] ref_fwd(input logic [4:0] q);
        if (q == 5'd0) return 33'd0;
        foreach (hist_a[i]) if (hist_a[i] == q) return {1'b1, hist_d[i]};
        return 33'd0;
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef WB_RETIRE_COUNT_EN
        return model_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        hist_a.delete();
        hist_d.delete();
        model_cnt = 32'd0;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] d,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [2:0] lt,
                         input logic [1:0] off, input logic st, input logic fl, input logic [4:0] q);
        logic [32:0] f;
        logic [31:0] wd;
        @(negedge clk);
        in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_dest = d;
        in_alu_result = alu; in_mem_data = mem; in_load_type = lt; in_byte_off = off;
        stall = st; flush = fl; query_addr = q;
        #1;
        f = ref_fwd(q);
        chk("in_ready", {31'd0, in_ready}, {31'd0, !st});
        chk("fwd_hit", {31'd0, fwd_hit}, {31'd0, f[32]});
        chk("fwd_data", fwd_data, f[31:0]);
        chk("retire_count", retire_count, exp_cnt());
        @(posedge clk);
        if (v && !st && !fl) begin
            model_cnt = model_cnt + 32'd1;
            if (rw && d != 5'd0) begin
                wd = ref_wdata(m2r, alu, mem, lt, off);
                exp_q.push_back('{t: $time, a: d, d: wd});
                hist_a.push_front(d);
                hist_d.push_front(wd);
                if (hist_a.size() > 2) begin
                    void'(hist_a.pop_back());
                    void'(hist_d.pop_back());
                end
            end
        end
        #1;
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input logic [4:0] q);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0, 1'b0, q);
    endtask

    task automatic query_chk(input logic [4:0] q, input logic hit, input logic [31:0] data);
        @(negedge clk);
        query_addr = q;
        #1;
        chk("q_hit", {31'd0, fwd_hit}, {31'd0, hit});
        chk("q_data", fwd_data, data);
    endtask

    task automatic load_chk(input string name, input logic [2:0] lt, input logic [1:0] off,
                            input logic [31:0] exp);
        drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h0, 32'h80FF7F01, lt, off, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        #1;
        chk(name, write_result, exp);
    endtask

    // Monitor: every write pulse must match the oldest expected write, one cycle after capture.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].t + 5 < $time) begin
            chk("missed_write", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        if (register_write) begin
            if (exp_q.size() == 0 || exp_q[0].t + 5 != $time) begin
                chk("unexpected_write", {31'd0, register_write}, 32'd0);
            end else begin
                chk("wr_addr", {27'd0, write_addr}, {27'd0, exp_q[0].a});
                chk("wr_data", write_result, exp_q[0].d);
                void'(exp_q.pop_front());
            end
        end else if (exp_q.size() > 0 && exp_q[0].t + 5 == $time) begin
            chk("missing_write", {31'd0, register_write}, 32'd1);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        model_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0; in_dest = 5'd0;
        in_alu_result = 32'd0; in_mem_data = 32'd0; in_load_type = 3'd0; in_byte_off = 2'd0;
        stall = 1'b1; flush = 1'b0; query_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wr", {31'd0, register_write}, 32'd0);
        chk("rst_result", write_result, 32'd0);
        chk("rst_addr", {27'd0, write_addr}, 32'd0);
        chk("rst_cnt", retire_count, 32'd0);
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;

        // ALU write then quiet
        drive(1'b1, 1'b1, 1'b0, 5'd8, 32'hDEADBEEF, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        #1;
        chk("alu_we", {31'd0, register_write}, 32'd1);
        chk("alu_addr", {27'd0, write_addr}, 32'd8);
        chk("alu_data", write_result, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("alu_we_drop", {31'd0, register_write}, 32'd0);
        chk("alu_hold", write_result, 32'hDEADBEEF);

        load_chk("lb3", 3'd1, 2'd3, 32'hFFFFFF80);
        load_chk("lbu3", 3'd2, 2'd3, 32'h00000080);
        load_chk("lh2", 3'd3, 2'd2, 32'hFFFF80FF);
        load_chk("lhu0", 3'd4, 2'd0, 32'h00007F01);
        load_chk("lw1", 3'd0, 2'd1, 32'h80FF7F01);

        // dest 0 counts but does not write; flush and stall do neither
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h55, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0, 5'd0);
        drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h66, 32'h0, 3'd0, 2'd0, 1'b0, 1'b1, 5'd7);
        drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h77, 32'h0, 3'd0, 2'd0, 1'b1, 1'b0, 5'd7);
        drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h88, 32'h0, 3'd0, 2'd0, 1'b1, 1'b1, 5'd7);
        idle(5'd7);
`ifdef WB_RETIRE_COUNT_EN
        chk("cnt_directed", retire_count, 32'd7);
`endif

        // forwarding
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h11, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0, 5'd0);
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h22, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0, 5'd3);
        query_chk(5'd3, 1'b1, 32'h22);
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h33, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0, 5'd3);
        query_chk(5'd3, 1'b1, 32'h22);
        query_chk(5'd4, 1'b1, 32'h33);
        query_chk(5'd0, 1'b0, 32'h0);

        // reset lands between presenting an instruction and its capture edge
        @(negedge clk);
        in_valid = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = 1'b0; in_dest = 5'd5;
        in_alu_result = 32'h1234; query_addr = 5'd5;
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_we", {31'd0, register_write}, 32'd0);
        chk("mid_rst_result", write_result, 32'd0);
        chk("mid_rst_addr", {27'd0, write_addr}, 32'd0);
        chk("mid_rst_hit", {31'd0, fwd_hit}, 32'd0);
        chk("mid_rst_cnt", retire_count, 32'd0);
        query_addr = 5'd4;
        #1;
        chk("mid_rst_hit4", {31'd0, fwd_hit}, 32'd0);
        rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 1'($urandom),
                  5'($urandom_range(0, 7)), $urandom, $urandom, 3'($urandom), 2'($urandom),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  5'($urandom_range(0, 7)));
        end
        idle(5'd0);
        idle(5'd0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
